// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver. Assembles WIDTH bits delimited by sof
// into a word and presents it on a registered valid/ready output slot.
// A finished word that finds the slot occupied is dropped and flagged on
// the sticky overrun output.
module shift_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] sr_first;
  logic             slot_free;

  // Next shift-register images: one more bit appended, or a fresh word
  // holding only the sof bit in the bit-0 position of the chosen order.
  always_comb begin
    sr_shifted = sr;
    sr_first   = '0;
    if (MSB_FIRST) begin
      sr_shifted = {sr[WIDTH-2:0], sin};
      sr_first   = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      sr_shifted = {sin, sr[WIDTH-1:1]};
      sr_first   = {sin, {(WIDTH-1){1'b0}}};
    end
    slot_free = !data_valid || data_ready;
  end

  // Receive FSM, output slot and overrun flag; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (overrun_clr) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (sin_en && sof) begin
            sr    <= sr_first;
            count <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sin_en) begin
            if (sof) begin
              sr    <= sr_first;
              count <= CW'(1);
            end else if (count == CW'(WIDTH - 1)) begin
              sr    <= sr_shifted;
              count <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (slot_free) begin
                data_out   <= sr_shifted;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              sr    <= sr_shifted;
              count <= count + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer. Two instances share one
// stimulus stream: one assembles MSB-first, the other LSB-first.
module tb_shift_deserializer;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic       sof;
  logic       data_ready;
  logic       overrun_clr;
  logic [7:0] msb_data;
  logic       msb_valid;
  logic       msb_busy;
  logic       msb_overrun;
  logic [7:0] lsb_data;
  logic       lsb_valid;
  logic       lsb_busy;
  logic       lsb_overrun;

  int n_checks;
  int n_fails;

  typedef struct {
    logic       rst;
    logic       sof;
    logic       sin_en;
    logic       sin;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_ovr;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vec [15];

  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sof(sof),
    .data_out(msb_data), .data_valid(msb_valid), .data_ready(data_ready),
    .busy(msb_busy), .overrun(msb_overrun), .overrun_clr(overrun_clr)
  );

  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sof(sof),
    .data_out(lsb_data), .data_valid(lsb_valid), .data_ready(data_ready),
    .busy(lsb_busy), .overrun(lsb_overrun), .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and return 1 time unit after the sampling edge.
  task automatic apply_stimulus(input logic r, input logic s_of, input logic en,
                                input logic b, input logic rdy, input logic clr);
    rst         = r;
    sof         = s_of;
    sin_en      = en;
    sin         = b;
    data_ready  = rdy;
    overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic valid, input logic bsy,
                              input logic ovr, input logic [7:0] msb_w);
    check_val({tag, " msb valid"}, 32'(msb_valid), 32'(valid));
    check_val({tag, " lsb valid"}, 32'(lsb_valid), 32'(valid));
    check_val({tag, " msb busy"}, 32'(msb_busy), 32'(bsy));
    check_val({tag, " lsb busy"}, 32'(lsb_busy), 32'(bsy));
    check_val({tag, " msb overrun"}, 32'(msb_overrun), 32'(ovr));
    check_val({tag, " lsb overrun"}, 32'(lsb_overrun), 32'(ovr));
    check_val({tag, " msb data"}, 32'(msb_data), 32'(msb_w));
    check_val({tag, " lsb data"}, 32'(lsb_data), 32'(rev8(msb_w)));
  endtask

  // Sends tx with tx[7] first; gaps of (i % (max_gap+1)) idle cycles follow
  // each non-final strobe, and both receivers must stay busy through them.
  task automatic send_frame(input logic [7:0] tx, input int max_gap,
                            input logic ready_last, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        apply_stimulus(1'b0, 1'b0, 1'b1, tx[7-i], ready_last, clr_last);
      end else begin
        apply_stimulus(1'b0, (i == 0), 1'b1, tx[7-i], 1'b0, 1'b0);
        for (int g = 0; g < (i % (max_gap + 1)); g++) begin
          apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          check_val("gap msb busy", 32'(msb_busy), 32'd1);
          check_val("gap lsb busy", 32'(lsb_busy), 32'd1);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // rst sof en sin rdy clr | valid busy ovr msb lsb
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vec[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAC, 8'h35};
    vec[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAC, 8'h35};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAC, 8'h35};
    vec[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAC, 8'h35};

    // Reset, stray bits in IDLE, basic frame 1,0,1,0,1,1,0,0 and one accept.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vec[i].rst, vec[i].sof, vec[i].sin_en, vec[i].sin,
                     vec[i].ready, vec[i].clr);
      check_val($sformatf("vec%0d msb valid", i), 32'(msb_valid), 32'(vec[i].exp_valid));
      check_val($sformatf("vec%0d lsb valid", i), 32'(lsb_valid), 32'(vec[i].exp_valid));
      check_val($sformatf("vec%0d msb busy", i), 32'(msb_busy), 32'(vec[i].exp_busy));
      check_val($sformatf("vec%0d lsb busy", i), 32'(lsb_busy), 32'(vec[i].exp_busy));
      check_val($sformatf("vec%0d msb overrun", i), 32'(msb_overrun), 32'(vec[i].exp_ovr));
      check_val($sformatf("vec%0d msb data", i), 32'(msb_data), 32'(vec[i].exp_msb));
      check_val($sformatf("vec%0d lsb data", i), 32'(lsb_data), 32'(vec[i].exp_lsb));
    end

    // Gapped strobes, bits 0,0,0,0,1,1,1,1: LSB-first word is F0.
    send_frame(8'h0F, 3, 1'b0, 1'b0);
    check_val("gapped lsb data", 32'(lsb_data), 32'h0000_00F0);
    check_output("gapped", 1'b1, 1'b0, 1'b0, 8'h0F);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("gapped accept", 1'b0, 1'b0, 1'b0, 8'h0F);

    // Overrun: second word dropped while clear is asserted (set wins).
    send_frame(8'hAC, 0, 1'b0, 1'b0);
    check_output("ovr first", 1'b1, 1'b0, 1'b0, 8'hAC);
    send_frame(8'hF0, 1, 1'b0, 1'b1);
    check_output("ovr drop", 1'b1, 1'b0, 1'b1, 8'hAC);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("ovr clear", 1'b1, 1'b0, 1'b0, 8'hAC);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("ovr accept", 1'b0, 1'b0, 1'b0, 8'hAC);

    // Acceptance and completion on the same edge.
    send_frame(8'hAC, 0, 1'b0, 1'b0);
    send_frame(8'h5A, 0, 1'b1, 1'b0);
    check_output("same cycle", 1'b1, 1'b0, 1'b0, 8'h5A);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("same accept", 1'b0, 1'b0, 1'b0, 8'h5A);

    // Resync: four bits of a frame, then a new sof restarts it.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("partial", 1'b0, 1'b1, 1'b0, 8'h5A);
    send_frame(8'h3C, 2, 1'b0, 1'b0);
    check_output("resync", 1'b1, 1'b0, 1'b0, 8'h3C);

    // Reset mid-frame with a word pending, then a clean frame.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("post reset", 1'b0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h81, 1, 1'b0, 1'b0);
    check_output("after reset", 1'b1, 1'b0, 1'b0, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-in, parallel-out receiver. Collects WIDTH bits from a one-bit serial stream and presents each completed word on a parallel output register with a valid/ready handshake.
- Receiving end for the team's parallel-load shifter: the shifter's serial output drives sin, its bit strobe drives sin_en and its start marker drives sof.
- Frames are delimited by sof. Words that cannot be delivered raise a sticky overrun flag.

Parameters:
- WIDTH, 8, word width in bits. Legal range 2..32.
- MSB_FIRST, 1, bit order. 1 = the first serial bit lands in data_out[WIDTH-1]. 0 = the first serial bit lands in data_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- sin  input  1  serial data bit. Sampled only when sin_en=1.
- sin_en  input  1  bit strobe. One bit is accepted per cycle where sin_en=1.
- sof  input  1  start of frame. Qualified by sin_en. Marks the bit on sin as bit 0 of a new word.
- data_out  output  WIDTH  completed word. Held stable while data_valid=1.
- data_valid  output  1  data_out holds an undelivered word.
- data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1.
- busy  output  1  a frame is partially received (state SHIFT).
- overrun  output  1  sticky. A completed word was dropped because the output register was occupied.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, bit count=0, shift register=0, data_out=0, data_valid=0, overrun=0, busy=0. Reset aborts any partial frame and discards any pending word.
- FSM state IDLE:
  - sin_en=1 and sof=1: capture sin as bit 0, count=1, go to SHIFT.
  - sin_en=1 and sof=0: ignore the bit; stay in IDLE.
- FSM state SHIFT (busy=1):
  - sin_en=1 and sof=0: shift in sin, count+1.
  - sin_en=0: hold all state. Gaps of any length are allowed.
  - sin_en=1 and sof=1: restart. Discard the partial word, capture sin as bit 0, count=1, stay in SHIFT. No overrun and no output.
- Shift direction:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- Word completion: occurs when sin_en=1 (sof=0) in SHIFT with count=WIDTH-1. The assembled word includes this bit. The FSM returns to IDLE on the same edge and count resets to 0.
  - If the output slot is free, the word loads into data_out and data_valid=1 on that same edge. The slot is free when data_valid=0, or when data_valid=1 and data_ready=1 in this cycle.
  - Otherwise the word is dropped; data_out and data_valid are unchanged and overrun <= 1.
- Latency: data_valid rises at the clk edge that samples the final bit. It is visible in the cycle after the final strobe.
- A new sof may be accepted in the cycle immediately after completion. Back-to-back frames have no dead cycle.
- Output handshake:
  - data_valid=1 and data_ready=1 with no completion in this cycle: data_valid <= 0 and data_out holds its value.
  - Acceptance and completion in the same cycle: data_out <= new word and data_valid stays 1.
  - data_ready is ignored when data_valid=0.
- overrun behaviour:
  - overrun_clr=1: overrun <= 0.
  - overrun_clr=1 and a drop in the same cycle: overrun <= 1 (the set wins).
  - overrun does not affect reception.
- WIDTH=2 is legal: sof bit plus one more bit completes the word.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Basic MSB-first: WIDTH=8, reset then release; sof+sin_en with bits 1,0,1,0,1,1,0,0 on consecutive cycles, data_ready=0 → data_out=8'hAC and data_valid=1 after the 8th strobe edge, busy=0 from that edge; data_ready=1 for one cycle → data_valid=0 and data_out still 8'hAC.
- Gapped strobes, LSB-first: MSB_FIRST=0, bits 0,0,0,0,1,1,1,1 with sin_en=0 gaps of 0–3 cycles between strobes → data_out=8'hF0; busy=1 throughout the gaps.
- Overrun: receive 8'hAC and hold data_ready=0; receive 8'hF0 → data_out stays 8'hAC and overrun=1; pulse overrun_clr → overrun=0; data_ready=1 → data_valid=0.
- Same-cycle accept and load: with 8'hAC pending, assert data_ready=1 on the completion cycle of 8'h5A → data_valid stays 1, data_out=8'h5A, overrun=0.
- Resync and reset: after 4 bits of a frame, assert sof with a new frame 8'h3C → output is 8'h3C only and no overrun. Then assert rst mid-frame (3 bits in) → all outputs 0 next cycle; the partial frame is never output; the next full frame 8'h81 is received correctly.
- Stray bits: sin_en pulses with sof=0 while in IDLE → busy stays 0, no data_valid, overrun unchanged.
